// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - 8-entry pixel write buffer draining to an Avalon-MM master write port
module write_buffer #(
    parameter int NUM_PIXELS = 8,
    parameter int ADDR_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [23:0] pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic        flush,
    output logic [31:0] master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    output logic [3:0]  master_byteenable,
    input  logic        master_waitrequest,
    output logic        done_write8,
    output logic        busy
);

    localparam int CW = $clog2(NUM_PIXELS + 1);
    localparam int IW = $clog2(NUM_PIXELS);
    localparam logic [CW-1:0] FULL = CW'(NUM_PIXELS);
    localparam logic [31:0]   STEP = 32'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_reg;
    logic [CW-1:0]  fill_cnt;
    logic [CW-1:0]  rd_idx;
    logic [CW-1:0]  fill_inc;
    logic [23:0]    buf_mem [0:NUM_PIXELS-1];
    logic           take;
    logic           accept;
    logic           last_write;
    logic           done_q;

    assign fill_inc = fill_cnt + CW'(1);

    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        accept     = 1'b0;
        last_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = WRITE == WRITE ? FILL : FILL;
            end
            FILL: begin
                take = pixel_valid;
                // A pixel arriving with flush is stored first and joins the batch.
                if ((take && fill_inc == FULL) || (flush && (take || fill_cnt != '0)))
                    state_d = WRITE;
            end
            WRITE: begin
                accept = !master_waitrequest;
                if (accept && rd_idx == fill_cnt - CW'(1)) begin
                    last_write = 1'b1;
                    state_d    = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In WRITE, fill_cnt holds the batch length since no pixels are taken then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_reg <= '0;
            fill_cnt <= '0;
            rd_idx   <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < NUM_PIXELS; i++) buf_mem[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= last_write;
            if (state_q == IDLE && start) begin
                addr_reg <= base_addr;
                fill_cnt <= '0;
                rd_idx   <= '0;
            end
            if (take) begin
                buf_mem[fill_cnt[IW-1:0]] <= pixel_in;
                fill_cnt                  <= fill_inc;
            end
            if (accept) begin
                addr_reg <= addr_reg + STEP;
                rd_idx   <= rd_idx + CW'(1);
            end
            if (last_write) begin
                fill_cnt <= '0;
                rd_idx   <= '0;
            end
        end
    end

    assign pixel_ready       = (state_q == FILL);
    assign master_write      = (state_q == WRITE);
    assign master_address    = addr_reg;
    assign master_writedata  = {8'h00, buf_mem[rd_idx[IW-1:0]]};
    assign master_byteenable = master_write ? 4'b0111 : 4'b0000;
    assign done_write8       = done_q;
    assign busy              = (state_q != IDLE);

endmodule
